// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   Valid/ready FIFO controller driving an external 1R1W synchronous RAM
//   (1-cycle read latency, read-during-write returns old data). Reads are
//   issued ahead of demand into a 2-entry output skid buffer so the consumer
//   sees a first-word-fall-through stream at one word per cycle.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
//   are both high in the preceding cycle. in_ready never depends on in_valid,
//   and out_valid never depends on out_ready. While out_valid is high and
//   out_ready is low, out_valid and out_data hold.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of all contents (beats push/pop)
//   in_valid/in_ready     producer handshake, in_data payload
//   out_valid/out_ready   consumer handshake, out_data = FIFO head
//   count                 entries held: RAM + read in flight + skid buffer
//   ram_waddr/wdata/we    RAM write port (combinational from push)
//   ram_raddr             RAM read address (always the read pointer)
//   ram_rdata             RAM read data, valid one cycle after ram_raddr

`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = `DATA_LEN,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;  // head of the skid buffer
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ;

  // Write side: RAM write is purely combinational from the accepted push.
  // rst_n is folded in so no RAM write can occur while reset is asserted.
  assign in_ready  = rst_n & ~flush & (ram_cnt_q < DEPTH_C);
  assign push      = in_valid & in_ready;
  assign ram_we    = push;
  assign ram_waddr = wptr_q;
  assign ram_wdata = in_data;
  assign ram_raddr = rptr_q;

  assign out_valid = (ob_cnt_q != 2'd0);
  assign out_data  = skid0_q;
  assign pop       = out_valid & out_ready;

  // Issue a read only while the skid buffer (counting the word already in
  // flight, minus the one leaving this cycle) has room. Using the registered
  // ram_cnt means a word written this cycle is never read in the same cycle,
  // so the read never collides with the write address.
  assign occ   = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
  assign issue = ~flush & (ram_cnt_q != '0) & (occ < (3'd2 + {2'b00, pop}));

  assign count = ram_cnt_q + (ADDR_WIDTH+1)'(inflight_q)
               + (ADDR_WIDTH+1)'(ob_cnt_q);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = issue;
    ob_cnt_d   = ob_cnt_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    if (flush) begin
      // Any returning RAM word is dropped because inflight/ob_cnt clear.
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = 2'd0;
    end else begin
      if (push)  wptr_d = wptr_q + 1'b1;
      if (issue) rptr_d = rptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
      // Skid buffer is a 2-deep shift FIFO: slot 0 is the head.
      case ({inflight_q, pop})
        2'b10: begin
          if (ob_cnt_q == 2'd0) skid0_d = ram_rdata;
          else                  skid1_d = ram_rdata;
          ob_cnt_d = ob_cnt_q + 2'd1;
        end
        2'b01: begin
          skid0_d  = skid1_q;
          ob_cnt_d = ob_cnt_q - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy unchanged.
          if (ob_cnt_q == 2'd2) begin
            skid0_d = skid1_q;
            skid1_d = ram_rdata;
          end else begin
            skid0_d = ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

endmodule
